// File: rtl/vram_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_fetch_arbiter
// Brief    : Shares single-port VRAM between the display line prefetcher and
//            the CPU bus. Fetches the next visible line into the idle half of
//            a double-buffered line buffer at the start of each raster line,
//            and interleaves CPU accesses between video words.
// Options  : VIDEO_FETCH_STRICT_PRIO_EN -- when defined, the video fetch has
//            strict priority and the CPU is served only outside line fetches.
// Revision : 1.0 - initial release
// ============================================================================
module vram_fetch_arbiter #(
  parameter int HRes          = 480,
  parameter int VRes          = 272,
  parameter int PixelsPerWord = 2,
  parameter int AddrWidth     = 17,
  parameter int DataWidth     = 16,
  parameter int FbBase        = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [9:0]           sx,
  input  logic [9:0]           sy,
  input  logic                 fetch_en,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AddrWidth-1:0] cpu_addr,
  input  logic [DataWidth-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DataWidth-1:0] cpu_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 lb_we,
  output logic                 lb_bank,
  output logic [9:0]           lb_addr,
  output logic [DataWidth-1:0] lb_wdata,
  output logic                 fetch_busy,
  output logic                 underrun
);

  // Words per visible line and derived constants
  localparam int                   c_W         = HRes / PixelsPerWord;
  localparam logic [9:0]           c_WORD_LAST = 10'(c_W - 1);
  localparam logic [9:0]           c_VRES      = 10'(VRes);
  localparam logic [9:0]           c_VRES_M1   = 10'(VRes - 1);
  localparam logic [AddrWidth-1:0] c_BASE      = AddrWidth'(FbBase);

  // Arbiter states
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_VID  = 2'd1;
  localparam logic [1:0] c_S_CPU  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;

  // Fetch context
  logic                 r_busy;
  logic [9:0]           r_line;
  logic [9:0]           r_word;
  logic                 r_discard;
  logic                 r_cpu_turn;

  // Registered outputs
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [AddrWidth-1:0] r_mem_addr;
  logic [DataWidth-1:0] r_mem_wdata;
  logic                 r_cpu_ack;
  logic [DataWidth-1:0] r_cpu_rdata;
  logic                 r_lb_we;
  logic                 r_lb_bank;
  logic [9:0]           r_lb_addr;
  logic [DataWidth-1:0] r_lb_wdata;
  logic                 r_underrun;

  // Combinational decode
  logic                 w_trig;
  logic [9:0]           w_trig_line;
  logic [9:0]           w_line_n;
  logic [9:0]           w_word_n;
  logic [AddrWidth-1:0] w_vid_addr;
  logic                 w_want_vid;
  logic                 w_want_cpu;
  logic                 w_grant_vid;
  logic                 w_grant_cpu;
  logic                 w_vid_done;
  logic                 w_cpu_done;
  logic                 w_keep;
  logic                 w_last;

  // Line-start trigger: next line during the visible area, line 0 from the
  // first blanking line; the last visible line has nothing left to prefetch.
  always_comb begin
    w_trig      = (sx == 10'd0) && fetch_en && ((sy < c_VRES_M1) || (sy == c_VRES));
    w_trig_line = (sy == c_VRES) ? 10'd0 : (sy + 10'd1);
  end

  // Line/word that the next video request uses; a fresh trigger restarts at
  // word 0 of the new line in the same cycle so the slot is not wasted.
  always_comb begin
    w_line_n   = w_trig ? w_trig_line : r_line;
    w_word_n   = w_trig ? 10'd0 : r_word;
    w_vid_addr = c_BASE + AddrWidth'(32'(w_line_n) * 32'(c_W) + 32'(w_word_n));
  end

  // Completion events and whether a video word lands in the line buffer
  always_comb begin
    w_vid_done = (r_state == c_S_VID) && mem_ack;
    w_cpu_done = (r_state == c_S_CPU) && mem_ack;
    w_keep     = w_vid_done && !r_discard && !w_trig;
    w_last     = (r_word == c_WORD_LAST);
    w_want_vid = r_busy || w_trig;
    // The request still held during the ack cycle is the one just served.
    w_want_cpu = cpu_req && !r_cpu_ack;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: issue from IDLE, return to IDLE on the VRAM acknowledge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_grant_vid) begin
          w_state_nxt = c_S_VID;
        end else if (w_grant_cpu) begin
          w_state_nxt = c_S_CPU;
        end
      end
      c_S_VID: begin
        if (mem_ack) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      c_S_CPU: begin
        if (mem_ack) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // Grant decision for the free slot
  always_comb begin
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    if (r_state == c_S_IDLE) begin
`ifdef VIDEO_FETCH_STRICT_PRIO_EN
      if (w_want_vid) begin
        w_grant_vid = 1'b1;
      end else if (w_want_cpu) begin
        w_grant_cpu = 1'b1;
      end
`else
      if (w_want_vid && w_want_cpu) begin
        // Alternate: the side that did not get the last slot goes next.
        w_grant_cpu = r_cpu_turn;
        w_grant_vid = !r_cpu_turn;
      end else if (w_want_vid) begin
        w_grant_vid = 1'b1;
      end else if (w_want_cpu) begin
        w_grant_cpu = 1'b1;
      end
`endif
    end
  end

  // Fetch context: line, word counter, busy flag and abort bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy     <= 1'b0;
      r_line     <= 10'd0;
      r_word     <= 10'd0;
      r_discard  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_trig && r_busy;
      if (w_trig) begin
        r_busy <= 1'b1;
        r_line <= w_trig_line;
        r_word <= 10'd0;
      end else if (w_keep) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_word <= 10'd0;
        end else begin
          r_word <= r_word + 10'd1;
        end
      end
      // A video read in flight when the fetch restarts belongs to the old line.
      if (w_vid_done) begin
        r_discard <= 1'b0;
      end else if ((r_state == c_S_VID) && w_trig) begin
        r_discard <= 1'b1;
      end
    end
  end

  // Alternation history: who completed the most recent access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cpu_turn <= 1'b0;
    end else if (w_vid_done) begin
      r_cpu_turn <= 1'b1;
    end else if (w_cpu_done) begin
      r_cpu_turn <= 1'b0;
    end
  end

  // VRAM request register: loaded on grant, held until the acknowledge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_vid) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= w_vid_addr;
      r_mem_wdata <= '0;
    end else if (w_grant_cpu) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= cpu_we;
      r_mem_addr  <= cpu_addr;
      r_mem_wdata <= cpu_wdata;
    end else if (w_vid_done || w_cpu_done) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Line-buffer write port: one cycle after each kept video word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lb_we    <= 1'b0;
      r_lb_bank  <= 1'b0;
      r_lb_addr  <= 10'd0;
      r_lb_wdata <= '0;
    end else begin
      r_lb_we <= w_keep;
      if (w_keep) begin
        r_lb_bank  <= r_line[0];
        r_lb_addr  <= r_word;
        r_lb_wdata <= mem_rdata;
      end
    end
  end

  // CPU completion: ack pulse one cycle after the VRAM ack, read data latched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ack <= w_cpu_done;
      if (w_cpu_done && !r_mem_we) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_rdata;
  assign lb_we      = r_lb_we;
  assign lb_bank    = r_lb_bank;
  assign lb_addr    = r_lb_addr;
  assign lb_wdata   = r_lb_wdata;
  assign fetch_busy = r_busy;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_fetch_arbiter
// Brief    : Self-checking bench for vram_fetch_arbiter. A VRAM responder with
//            programmable latency serves requests from a sparse memory; an
//            access-level model lists the VRAM accesses, line-buffer writes and
//            CPU completions each scenario must produce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_fetch_arbiter;

  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [9:0]    sx, sy;
  logic          fetch_en;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          lb_we, lb_bank;
  logic [9:0]    lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          fetch_busy, underrun;

  always #5 clk = ~clk;

  vram_fetch_arbiter #(
    .HRes(8), .VRes(4), .PixelsPerWord(2),
    .AddrWidth(AW), .DataWidth(DW), .FbBase(32'h100)
  ) dut (
    .clk(clk), .rstn(rstn), .sx(sx), .sy(sy), .fetch_en(fetch_en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .underrun(underrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory contents and access-level model ----------------
  logic [DW-1:0] ram [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          vid;
    logic          keep;
    logic [DW-1:0] rdata;
    logic          bank;
    logic [9:0]    lbaddr;
  } acc_t;

  acc_t expq[$];

  // Video word w of line L: address base + L*4 + w, lands in bank L[0] slot w.
  task automatic push_vid(input int l, input int w, input bit keep);
    acc_t e;
    e.addr   = AW'(32'h100 + l * 4 + w);
    e.we     = 1'b0;
    e.wdata  = '0;
    e.vid    = 1'b1;
    e.keep   = keep;
    e.rdata  = init_val(e.addr);
    e.bank   = l[0];
    e.lbaddr = 10'(w);
    expq.push_back(e);
  endtask

  task automatic push_line(input int l);
    for (int w = 0; w < 4; w++) push_vid(l, w, 1'b1);
  endtask

  task automatic push_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd);
    acc_t e;
    e.addr   = a;
    e.we     = we;
    e.wdata  = wd;
    e.vid    = 1'b0;
    e.keep   = 1'b0;
    e.rdata  = rd;
    e.bank   = 1'b0;
    e.lbaddr = 10'd0;
    expq.push_back(e);
  endtask

  // ---------------- VRAM responder ----------------
  int ack_delay = 1;
  int rcnt      = 0;

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (rcnt >= ack_delay) begin
        mem_ack = 1'b1;
        rcnt    = 0;
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata     = ram_rd(mem_addr);
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  acc_t          cur;
  bit            prev_req = 1'b0;
  bit            prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            n_lb    = 0;
  int            n_under = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_ack && cur.vid && cur.keep) begin
        check("lb_we", lb_we, 1);
        check("lb_bank", lb_bank, cur.bank);
        check("lb_addr", lb_addr, cur.lbaddr);
        check("lb_wdata", lb_wdata, cur.rdata);
      end else begin
        check("lb_we_quiet", lb_we, 0);
      end
      if (prev_ack && !cur.vid) begin
        check("cpu_ack", cpu_ack, 1);
        if (!cur.we) check("cpu_rdata", cpu_rdata, cur.rdata);
      end else begin
        check("cpu_ack_quiet", cpu_ack, 0);
      end
      if (mem_req && !prev_req) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected: got request to 0x%0h, expected none (t=%0t)", mem_addr, $time);
        end else begin
          cur = expq.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", mem_we, cur.we);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) begin
        check("mem_hold", mem_addr, prev_addr);
      end
      if (lb_we) n_lb++;
      if (underrun) n_under++;
      prev_ack  = mem_req && mem_ack;
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic trigger(input int line_sy, input bit expect_issue, input logic [AW-1:0] exp_addr);
    sx = 10'd0;
    sy = 10'(line_sy);
    @(negedge clk);
    sx = 10'd5;
    if (expect_issue) begin
      check("trig_req_latency", mem_req, 1);
      check("trig_first_addr", mem_addr, exp_addr);
      check("trig_busy", fetch_busy, 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!fetch_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_idle: fetch_busy still 1 after %0d cycles, expected 0", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output logic [DW-1:0] rd);
    bit ok = 1'b0;
    rd        = '0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        ok = 1'b1;
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL cpu_timeout: no cpu_ack for 0x%0h, expected one", a);
    end
  endtask

  task automatic wait_sig(input string name, input int which, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && lb_we) || (which == 1 && mem_req)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: event not seen in %0d cycles, expected it", name, budget);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int            lb0, u0;
    logic [DW-1:0] rd;
    rstn = 1'b0; sx = 10'd5; sy = 10'd0; fetch_en = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_lb_bank", lb_bank, 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_lb_wdata", lb_wdata, 0);
    check("rst_fetch_busy", fetch_busy, 0);
    check("rst_underrun", underrun, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch: line 1 from 0x104..0x107 into bank 1.
    ack_delay = 1;
    lb0 = n_lb;
    push_line(1);
    trigger(0, 1'b1, 17'h104);
    wait_idle(100);
    check("single_lb_count", n_lb - lb0, 4);

    // Frame wrap: sy=VRes fetches line 0; sy=VRes-1 fetches nothing.
    lb0 = n_lb;
    push_line(0);
    trigger(4, 1'b1, 17'h100);
    wait_idle(100);
    check("wrap_lb_count", n_lb - lb0, 4);
    trigger(3, 1'b0, '0);
    check("last_line_no_req", mem_req, 0);
    check("last_line_no_busy", fetch_busy, 0);
    repeat (4) @(negedge clk);

    // Contention: CPU read of 0x1FF raised while line 2 is fetching.
`ifdef VIDEO_FETCH_STRICT_PRIO_EN
    push_line(2);
    push_cpu(1'b0, 17'h1FF, '0, init_val(17'h1FF));
`else
    push_vid(2, 0, 1'b1);
    push_cpu(1'b0, 17'h1FF, '0, init_val(17'h1FF));
    push_vid(2, 1, 1'b1);
    push_vid(2, 2, 1'b1);
    push_vid(2, 3, 1'b1);
`endif
    trigger(1, 1'b1, 17'h108);
    cpu_access(1'b0, 17'h1FF, '0, rd);
    check("contention_rdata_literal", rd, 16'h5BC3);
    wait_idle(100);

    // Underrun: slow VRAM, trigger again while word 1 of line 1 is in flight.
    ack_delay = 10;
    lb0 = n_lb;
    u0  = n_under;
    push_vid(1, 0, 1'b1);
    push_vid(1, 1, 1'b0);
    push_line(2);
    trigger(0, 1'b1, 17'h104);
    wait_sig("underrun_word0_lb", 0, 50);
    wait_sig("underrun_word1_req", 1, 20);
    repeat (3) @(negedge clk);
    trigger(1, 1'b0, '0);
    check("underrun_pulse", underrun, 1);
    check("underrun_still_busy", fetch_busy, 1);
    @(negedge clk);
    check("underrun_one_cycle", underrun, 0);
    wait_idle(300);
    check("underrun_count", n_under - u0, 1);
    check("underrun_lb_count", n_lb - lb0, 5);

    // Asynchronous reset while a request is outstanding.
    push_vid(3, 0, 1'b1);
    trigger(2, 1'b1, 17'h10C);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_fetch_busy", fetch_busy, 0);
    check("arst_lb_we", lb_we, 0);
    check("arst_cpu_ack", cpu_ack, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    ack_delay = 1;
    lb0 = n_lb;
    push_line(3);
    trigger(2, 1'b1, 17'h10C);
    wait_idle(100);
    check("post_reset_lb_count", n_lb - lb0, 4);

    // Fetch disabled: no video request, CPU write/read still served.
    fetch_en = 1'b0;
    trigger(0, 1'b0, '0);
    check("fetch_dis_no_req", mem_req, 0);
    check("fetch_dis_no_busy", fetch_busy, 0);
    push_cpu(1'b1, 17'h050, 16'hBEEF, '0);
    cpu_access(1'b1, 17'h050, 16'hBEEF, rd);
    push_cpu(1'b0, 17'h050, '0, 16'hBEEF);
    cpu_access(1'b0, 17'h050, '0, rd);
    check("cpu_readback_literal", rd, 16'hBEEF);
    fetch_en = 1'b1;

    repeat (5) @(negedge clk);
    check("model_queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
